// File: rtl/macrow_seq_ctrl_if.sv
// Command, operand-memory, MAC-row and result signals of the MAC row sequencer.
// slave is the sequencer's view; master is the host/memory/row side.
interface macrow_seq_ctrl_if #(
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int NCOL  = 4,
    parameter int LEN_W = 8
);
    logic             start_i;
    logic [AW-1:0]    w_base_i;
    logic [AW-1:0]    x_base_i;
    logic [LEN_W-1:0] x_len_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             mem_rd_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DW-1:0]    mem_rdata_i;
    logic [NCOL-1:0]  enw_o;
    logic [DW-1:0]    w_o;
    logic             enx_o;
    logic [DW-1:0]    x_o;
    logic             valid_i;
    logic [DW-1:0]    y_i;
    logic             y_valid_o;
    logic [DW-1:0]    y_o;
    logic [LEN_W-1:0] y_idx_o;

    modport slave (
        input  start_i, w_base_i, x_base_i, x_len_i, mem_rdata_i, valid_i, y_i,
        output busy_o, done_o, err_o, mem_rd_o, mem_addr_o, enw_o, w_o, enx_o, x_o,
               y_valid_o, y_o, y_idx_o
    );

    modport master (
        output start_i, w_base_i, x_base_i, x_len_i, mem_rdata_i, valid_i, y_i,
        input  busy_o, done_o, err_o, mem_rd_o, mem_addr_o, enw_o, w_o, enx_o, x_o,
               y_valid_o, y_o, y_idx_o
    );
endinterface

// File: rtl/macrow_seq_ctrl.sv
// Sequencer for the 4-column MAC row: loads NCOL weights, streams x_len X operands,
// collects results with a drain watchdog, then pulses done.
module macrow_seq_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int NCOL    = 4,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    macrow_seq_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOADW, STREAMX, DRAIN, DONE} state_e;

    localparam int              WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [NCOL-1:0] WSEL0 = NCOL'(1) << (NCOL - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    w_base_q, w_base_d, x_base_q, x_base_d, mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0] x_len_q, x_len_d, cnt_q, cnt_d, rcnt_q, rcnt_d, y_idx_q, y_idx_d;
    logic [NCOL-1:0]  wsel_q, wsel_d, enw_q, enw_d;
    logic             rd_w_q, rd_w_d, rd_x_q, rd_x_d, enx_q, enx_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, y_valid_q, y_valid_d;
    logic [DW-1:0]    w_q, w_d, x_q, x_d, y_q, y_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             valid_acc;

    always_comb begin
        state_d    = state_q;
        w_base_d   = w_base_q;
        x_base_d   = x_base_q;
        x_len_d    = x_len_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        wsel_d     = wsel_q;
        busy_d     = busy_q;
        err_d      = err_q;
        done_d     = 1'b0;
        rd_w_d     = 1'b0;
        rd_x_d     = 1'b0;
        y_d        = y_q;
        y_idx_d    = y_idx_q;

        valid_acc = bus.valid_i && (state_q == STREAMX || state_q == DRAIN) && (rcnt_q < x_len_q);
        rcnt_d    = rcnt_q + LEN_W'(valid_acc);
        y_valid_d = valid_acc;
        if (valid_acc) begin
            y_d     = bus.y_i;
            y_idx_d = rcnt_q;
        end

        // Row strobes trail the read strobe by one cycle, matching memory latency.
        enw_d = rd_w_q ? wsel_q : '0;
        enx_d = rd_x_q;
        w_d   = (enw_q != '0) ? bus.mem_rdata_i : w_q;
        x_d   = enx_q ? bus.mem_rdata_i : x_q;
        wd_d  = (valid_acc || enx_q || state_q != DRAIN) ? '0 : wd_q + 1'b1;

        case (state_q)
            IDLE: if (bus.start_i) begin
                w_base_d   = bus.w_base_i;
                x_base_d   = bus.x_base_i;
                x_len_d    = bus.x_len_i;
                err_d      = 1'b0;
                busy_d     = 1'b1;
                rcnt_d     = '0;
                rd_w_d     = 1'b1;
                wsel_d     = WSEL0;
                mem_addr_d = bus.w_base_i;
                cnt_d      = LEN_W'(1);
                state_d    = LOADW;
            end
            LOADW: begin
                if (cnt_q < LEN_W'(NCOL)) begin
                    rd_w_d     = 1'b1;
                    wsel_d     = wsel_q >> 1;
                    mem_addr_d = w_base_q + AW'(cnt_q);
                    cnt_d      = cnt_q + 1'b1;
                end else if (x_len_q != '0) begin
                    // First X read overlaps the final enw pulse.
                    rd_x_d     = 1'b1;
                    mem_addr_d = x_base_q;
                    cnt_d      = LEN_W'(1);
                    state_d    = STREAMX;
                end else begin
                    state_d = DONE;
                end
            end
            STREAMX: begin
                if (cnt_q < x_len_q) begin
                    rd_x_d     = 1'b1;
                    mem_addr_d = x_base_q + AW'(cnt_q);
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rcnt_d == x_len_q) begin
                    state_d = DONE;
                end else if (wd_d == WD_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            w_base_q   <= '0;
            x_base_q   <= '0;
            x_len_q    <= '0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            wsel_q     <= '0;
            enw_q      <= '0;
            rd_w_q     <= 1'b0;
            rd_x_q     <= 1'b0;
            enx_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            w_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            y_idx_q    <= '0;
            y_valid_q  <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            w_base_q   <= w_base_d;
            x_base_q   <= x_base_d;
            x_len_q    <= x_len_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            wsel_q     <= wsel_d;
            enw_q      <= enw_d;
            rd_w_q     <= rd_w_d;
            rd_x_q     <= rd_x_d;
            enx_q      <= enx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            w_q        <= w_d;
            x_q        <= x_d;
            y_q        <= y_d;
            y_idx_q    <= y_idx_d;
            y_valid_q  <= y_valid_d;
            wd_q       <= wd_d;
        end
    end

    // Read data is live in the strobe cycle, so operands bypass their hold registers.
    assign bus.w_o        = (enw_q != '0) ? bus.mem_rdata_i : w_q;
    assign bus.x_o        = enx_q ? bus.mem_rdata_i : x_q;
    assign bus.enw_o      = enw_q;
    assign bus.enx_o      = enx_q;
    assign bus.mem_rd_o   = rd_w_q | rd_x_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.y_valid_o  = y_valid_q;
    assign bus.y_o        = y_q;
    assign bus.y_idx_o    = y_idx_q;
endmodule
